// File: rtl/aes_feeder_pkg.sv
// aes_feeder_pkg
//   Shared constants and the feeder FSM state type for the AES feeder slice.
//   Contents: WORD_W (input word width), BLK_WORDS (words per block),
//   BLK_W (AES block width), fsm_state_e (FILL / ISSUE).
package aes_feeder_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_WORDS = 4;
    localparam int unsigned BLK_W     = WORD_W * BLK_WORDS;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/aes_result_fifo.sv
// aes_result_fifo
//   Small result FIFO holding AES ciphertext blocks until the consumer takes
//   them. DEPTH must be a power of two so the pointers wrap for free.
//   Ports:
//     clk_i        clock, rising edge
//     rst_ni       asynchronous active-low reset (pointers and count cleared)
//     push_i       write push_data_i at the tail (ignored when full)
//     push_data_i  block to store
//     pop_i        drop the head entry (ignored when empty)
//     data_o       head entry
//     count_o      number of stored entries (0..DEPTH)
module aes_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && (count_q != FULL);
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/aes_feeder.sv
// aes_feeder
//   Packs 32-bit words into 128-bit AES blocks, presents plaintext/key to an
//   external fixed-latency AES core, tracks in-flight blocks with a valid
//   shift register and queues the core results in a credit-protected FIFO.
//   Optional build macro: AES_FEEDER_KEYLOCK_EN -- when defined, the first
//   word of a key sequence is refused while any block is in flight or queued.
//   Ports:
//     clk         clock, rising edge
//     rst         asynchronous active-low reset
//     in_valid    input word valid
//     in_ready    feeder accepts the word
//     in_data     plaintext or key word (first word -> bits [127:96])
//     in_is_key   sequence type, sampled on the first word only
//     core_state  registered plaintext to the core
//     core_key    registered active key to the core
//     core_out    core ciphertext, valid LATENCY edges after core sampling
//     out_valid   result FIFO non-empty
//     out_ready   consumer accepts the head result
//     out_data    head result
//     busy        block issuing, in flight, or queued
module aes_feeder
    import aes_feeder_pkg::*;
#(
    parameter int unsigned LATENCY    = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_is_key,
    output logic [BLK_W-1:0]  core_state,
    output logic [BLK_W-1:0]  core_key,
    input  logic [BLK_W-1:0]  core_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic              busy
);

    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    fsm_state_e                      state_q;
    logic [1:0]                      cnt_q;
    logic                            is_key_q;
    logic [BLK_W-WORD_W-1:0]         buf_q;
    logic [BLK_W-1:0]                core_state_q;
    logic [BLK_W-1:0]                core_key_q;
    logic [LATENCY-1:0]              vld_q, vld_d;
    logic [CW-1:0]                   inflight_q, inflight_d;
    logic [CW-1:0]                   fifo_cnt;
    logic [CW:0]                     credit_used;
    logic                            xfer;
    logic                            issue;
    logic                            capture;

    assign xfer        = in_valid && in_ready;
    assign issue       = (state_q == ISSUE);
    assign capture     = vld_q[LATENCY-1];
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign busy        = issue || (inflight_q != '0) || (fifo_cnt != '0);
    assign out_valid   = (fifo_cnt != '0);
    assign core_state  = core_state_q;
    assign core_key    = core_key_q;

    // Only the last data word needs a credit: it is the one that commits a
    // result slot, so earlier words can keep streaming while the FIFO drains.
    always_comb begin
        in_ready = 1'b1;
        if (issue) begin
            in_ready = 1'b0;
        end else if ((cnt_q == 2'd3) && !is_key_q && (credit_used >= CREDIT_MAX)) begin
            in_ready = 1'b0;
        end
`ifdef AES_FEEDER_KEYLOCK_EN
        else if ((cnt_q == 2'd0) && in_is_key && busy) begin
            in_ready = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            is_key_q     <= 1'b0;
            buf_q        <= '0;
            core_state_q <= '0;
            core_key_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 2'd1;
                        buf_q <= {buf_q[BLK_W-2*WORD_W-1:0], in_data};
                        if (cnt_q == 2'd0) is_key_q <= in_is_key;
                        if (cnt_q == 2'd3) begin
                            if (is_key_q) begin
                                core_key_q <= {buf_q, in_data};
                            end else begin
                                core_state_q <= {buf_q, in_data};
                                state_q      <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: state_q <= FILL;
            endcase
        end
    end

    // The issue pulse enters stage 0 on the edge that leaves ISSUE, which is
    // the same edge on which the core samples core_state/core_key.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_comb begin
        case ({issue, capture})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    aes_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BLK_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (capture),
        .push_data_i (core_out),
        .pop_i       (out_valid && out_ready),
        .data_o      (out_data),
        .count_o     (fifo_cnt)
    );

endmodule

// File: tb/tb_aes_feeder.sv
`timescale 1ns/1ps
module tb_aes_feeder;

    localparam int unsigned LAT   = 11;
    localparam int unsigned DEPTH = 4;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3  = 128'hfedcba98765432100123456789abcdef;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_is_key;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [127:0] sb [$];
    logic [127:0] model_key = '0;
    logic [127:0] core_pipe [LAT];

    aes_feeder #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_is_key  (in_is_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in AES core: the real answer for the known test vector, a cheap
    // keyed mix otherwise; fixed LAT-edge pipeline from sampling to core_out.
    function automatic logic [127:0] cipher(input logic [127:0] s, input logic [127:0] k);
        if (s == PT && k == KEY) return CT;
        return s ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= cipher(core_state, core_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LAT-1];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a result leaves the DUT on every edge where
    // out_valid && out_ready, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got=%h exp=none", out_data);
            end else begin
                check("result", out_data, sb.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic k);
        bit ok = 0;
        in_valid  = 1'b1;
        in_data   = w;
        in_is_key = k;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) check("word_accept_timeout", 128'(ok), 128'd1);
    endtask

    // kpat[3] is the in_is_key value on word 0; it alone decides the type.
    task automatic send_block(input logic [127:0] blk, input logic [3:0] kpat);
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], kpat[3-i]);
        if (kpat[3]) model_key = blk;
        else sb.push_back(cipher(blk, model_key));
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           c0;
        int           stalled;
        bit           ok;
        bit           bz;
        bit           seen;
        logic [127:0] blk;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_core_state", core_state, '0);
        check("rst_core_key", core_key, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        check("post_rst_out_valid", 128'(out_valid), 128'd0);

        // Known-answer vector and exact result latency.
        for (int i = 0; i < 3; i++) send_word(KEY[127-32*i -: 32], 1'b1);
        check("key_not_early", core_key, '0);
        send_word(KEY[31:0], 1'b1);
        model_key = KEY;
        check("key_loaded", core_key, KEY);
        check("key_no_issue", 128'(busy), 128'd0);
        send_block(PT, 4'b0000);
        check("state_loaded", core_state, PT);
        check("issue_in_ready", 128'(in_ready), 128'd0);
        repeat (LAT) @(posedge clk);
        #1;
        check("kat_not_early", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("kat_valid", 128'(out_valid), 128'd1);
        check("kat_data", out_data, CT);
        drain();

        // Back-to-back blocks with the consumer always ready: 5 cycles each.
        send_block(128'h00112233445566778899aabbccddeeff, 4'b0000);
        c0 = cyc;
        send_block(128'h0123456789abcdef0123456789abcdef, 4'b0000);
        send_block(128'hdeadbeefcafef00d0badc0de12345678, 4'b0000);
        check("throughput", 128'(cyc - c0), 128'd10);
        drain();

        // Consumer stalled: four results fill the credit, fifth block waits.
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            blk = {4{32'ha5000000 + 32'(b)}};
            send_block(blk, 4'b0000);
        end
        blk = {4{32'h5a000004}};
        for (int i = 0; i < 3; i++) send_word(blk[127-32*i -: 32], 1'b0);
        stalled = 0;
        fork
            send_word(blk[31:0], 1'b0);
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (!in_ready) stalled++;
                end
                check("full_out_valid", 128'(out_valid), 128'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        sb.push_back(cipher(blk, model_key));
        check("credit_stall", 128'(stalled), 128'd30);
        drain();

        // Push and pop on the same edge with one entry queued.
        out_ready = 1'b0;
        send_block(128'h11111111222222223333333344444444, 4'b0000);
        blk = 128'h55555555666666667777777788888888;
        send_block(blk, 4'b0000);
        repeat (LAT) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("pushpop_valid", 128'(out_valid), 128'd1);
        check("pushpop_head", out_data, cipher(blk, model_key));
        @(posedge clk);
        #1;
        check("pushpop_hold", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pushpop_count1", 128'(out_valid), 128'd0);
        drain();

        // Reset with a partial block and two blocks in flight.
        send_block(128'h99999999aaaaaaaabbbbbbbbcccccccc, 4'b0000);
        send_block(128'hddddddddeeeeeeeeffffffff00000000, 4'b0000);
        send_word(32'h13579bdf, 1'b0);
        send_word(32'h2468ace0, 1'b0);
        check("pre_rst_busy", 128'(busy), 128'd1);
        rst = 1'b0;
        sb.delete();
        model_key = '0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_core_key", core_key, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("no_stale_result", 128'(seen), 128'd0);
        @(posedge clk);
        #1;
        send_block(128'hfeedface0000111122223333c0ffee00, 4'b0000);
        drain();

        // Key word 0 offered while a block is in flight.
        send_block(128'h0badf00d0badf00d0badf00d0badf00d, 4'b0000);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = K2[127:96];
        in_is_key = 1'b1;
        @(negedge clk);
`ifdef AES_FEEDER_KEYLOCK_EN
        check("keylock_refuse", 128'(in_ready), 128'd0);
`else
        check("key_immediate", 128'(in_ready), 128'd1);
`endif
        ok = in_ready;
        bz = busy;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            @(negedge clk);
            ok = in_ready;
            bz = busy;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("key_word0_accepted", 128'(ok), 128'd1);
`ifdef AES_FEEDER_KEYLOCK_EN
        check("key_after_idle", 128'(bz), 128'd0);
`else
        check("key_while_busy", 128'(bz), 128'd1);
`endif
        for (int i = 1; i < 4; i++) send_word(K2[127-32*i -: 32], 1'b1);
        model_key = K2;
        check("key2_loaded", core_key, K2);
        send_block(128'h0f0e0d0c0b0a09080706050403020100, 4'b0000);
        drain();

        // in_is_key changes after word 0 are ignored.
        blk = 128'h8badf00d8badf00d8badf00d8badf00d;
        send_block(blk, 4'b0111);
        send_block(K3, 4'b1000);
        check("key3_loaded", core_key, K3);
        check("state_held", core_state, blk);
        send_block(128'h1234567890abcdef1234567890abcdef, 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_feeder.md
AES_FEEDER -- requirements
Module: aes_feeder

Interface
REQ-001 Parameter LATENCY, default 11, core edges from core sampling of core_state/core_key to matching core_out.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, result FIFO entries.
REQ-003 Port clk  input  1  the single clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  input word valid.
REQ-006 Port in_ready  output  1  feeder accepts word.
REQ-007 Port in_data  input  32  plaintext or key word.
REQ-008 Port in_is_key  input  1  word sequence is key (sampled on first word only).
REQ-009 Port core_state  output  128  registered plaintext to AES core.
REQ-010 Port core_key  output  128  registered active key to AES core.
REQ-011 Port core_out  input  128  AES core ciphertext.
REQ-012 Port out_valid  output  1  result FIFO non-empty.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port out_data  output  128  FIFO head ciphertext.
REQ-015 Port busy  output  1  any block in flight or FIFO non-empty.

Function
REQ-016 Word transfer occurs when in_valid && in_ready; 4 transfers form one sequence; first word maps to bits [127:96], last to [31:0].
REQ-017 FSM states FILL, ISSUE; FILL counts words 0..3, wraps to 0 after word 3; type latched from in_is_key on word 0.
REQ-018 Key sequence: on 4th word, core_key updates atomically next edge; no issue; FSM stays FILL.
REQ-019 Data sequence: on 4th word, core_state loads, FSM enters ISSUE for exactly one cycle, issue pulse inserted into LATENCY-deep valid shift register, then returns FILL.
REQ-020 in_ready low in ISSUE, and low on data word 3 when (inflight + fifo_count) == FIFO_DEPTH (credit rule); FIFO shall never overflow.
REQ-021 When issue pulse exits shift register, core_out captured into FIFO tail same edge.
REQ-022 FIFO pop when out_valid && out_ready; simultaneous push and pop keeps count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 inflight counter +1 on issue, -1 on capture, unchanged when both same cycle; width clog2(FIFO_DEPTH)+1.
REQ-024 Sustained throughput one block per 5 cycles with out_ready held high.
REQ-025 core_state and core_key hold value between loads.

Reset
REQ-026 rst low asynchronously clears: FSM=FILL, word count 0, core_state=0, core_key=0, shift register 0, inflight 0, FIFO pointers 0; out_valid=0, busy=0, in_ready=1 one edge after release.
REQ-027 Reset mid-sequence or with blocks in flight discards partial words and all in-flight/FIFO results; no out_valid after release until a new block completes.

Configuration
REQ-028 Macro AES_FEEDER_KEYLOCK_EN defined: in_ready low for key word 0 while busy is high; key sequences never overlap in-flight blocks.
REQ-029 Macro undefined: key words accepted regardless of busy; in-flight blocks finish with whichever key the core sampled.

Structure
REQ-030 Package aes_feeder_pkg holds WORD_W=32, BLK_WORDS=4, BLK_W=128, FSM state enumeration.
REQ-031 Sub-module aes_result_fifo (push/pop/count, FIFO_DEPTH x 128) instantiated once; shift register and FSM in aes_feeder.

Verification
REQ-032 Key words 2b7e1516,28aed2a6,abf71588,09cf4f3c then data 3243f6a8,885a308d,313198a2,e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32 exactly LATENCY+1 edges after ISSUE.
REQ-033 out_ready low, 5 data blocks back-to-back -> 4 results queued, in_ready low on 5th block word 3 until one pop; no result lost or reordered.
REQ-034 Push and pop same cycle with FIFO at 1 entry -> count stays 1, out_data advances to next result.
REQ-035 rst low after 2 data words and with 2 blocks in flight -> out_valid stays 0; next full block produces correct single result.
REQ-036 AES_FEEDER_KEYLOCK_EN defined, key word 0 offered while busy -> in_ready 0 until busy falls, then key accepted; undefined -> accepted immediately.
REQ-037 in_is_key toggled on words 1-3 -> ignored; sequence type follows word 0.
